register_bank_8x16: RTL
=======================

Name: register_bank_8x16

Overview:
- Eight-entry, 16-bit general-purpose register bank for the single-cycle RISC datapath.
- Sits directly upstream of the 8-to-1 16-bit operand multiplexers.
- All eight registers are driven out in parallel on R0..R7, which wire straight to mux inputs I0..I7.
- Two internal read ports (A/B) are also provided for direct operand fetch and for debug.
- A single synchronous write port supports byte enables, so the datapath can execute byte loads and load-upper-immediate without read-modify-write.

Parameters:
- WIDTH, 16, register width in bits; must be even. Byte lanes are WIDTH/2 each.
- R0_ZERO, 1, when 1, R0 is hardwired to zero and writes to address 0 are discarded.
- BYPASS, 0, when 1, read ports A/B return write data in the same cycle as a write to the same address (write-through). When 0, they return the stored value.
- R7_RESET, 16'h0000, reset value of R7 (stack pointer).

Ports:
- CLK, input, 1, system clock; all state updates on the rising edge.
- RST, input, 1, asynchronous active-high reset.
- WE, input, 1, write enable.
- WA, input, 3, write address.
- WD, input, WIDTH, write data.
- BE, input, 2, byte enables: BE[0] selects the low byte lane, BE[1] selects the high byte lane.
- RA, input, 3, read port A address.
- RB, input, 3, read port B address.
- QA, output, WIDTH, read port A data (combinational).
- QB, output, WIDTH, read port B data (combinational).
- R0..R7, output, WIDTH each, current contents of each register; feed mux I0..I7.
- WR_CNT, output, 8, count of committed writes, for bench and debug.

Behaviour:
- Reset:
  - RST asserted forces, asynchronously and independent of CLK, R0..R6 to 0, R7 to R7_RESET, and WR_CNT to 0.
  - While RST is held high, all writes are ignored.
  - Deassertion is sampled at the next rising edge; the first write can commit on the first rising edge with RST low.
- Write:
  - On a rising edge with WE=1, lane k of register WA is loaded from the WD lane k, for each k with BE[k]=1.
  - Lanes with BE[k]=0 retain their value.
- Null writes:
  - WE=1 with BE=2'b00 is a no-op and does not increment WR_CNT.
  - If R0_ZERO=1, WE=1 with WA=0 is a no-op, R0 stays 0, and WR_CNT does not increment.
- WR_CNT:
  - Increments by 1 on every committed write, i.e. WE=1, BE!=0, and not the R0_ZERO discard case.
  - Wraps from 255 to 0.
- Read:
  - QA = register[RA] and QB = register[RB], purely combinational, zero latency.
  - R0..R7 reflect register state after the edge; there is no bypass on R0..R7.
- Bypass (BYPASS=1):
  - When WE=1, BE!=0, and RA==WA (and not the R0_ZERO discard case), QA shows the merged value: WD in enabled lanes and the stored value in disabled lanes.
  - QB follows the same rule for RB.
  - With BYPASS=0, QA/QB show pre-edge contents until the edge.
- Same-address reads: RA==RB is legal, and both ports return identical data.
- Reset mid-write: if RST rises in the same cycle as a write, reset wins. No partial lane update may be visible after reset.
- Width rules: BE lane boundaries are bits [WIDTH/2-1:0] and [WIDTH-1:WIDTH/2]. There are no sign or zero extension duties; callers pre-align WD.

Test Plan:
- Reset check: RST=1 pulse mid-cycle with R7_RESET=16'hFFF0 -> immediately R0..R6=16'h0000, R7=16'hFFF0, WR_CNT=0, with no clock edge required.
- Full-word writes then reads: write WA=1..7 with WD=16'h00BC, 16'h009A, 16'h0078, 16'h0056, 16'h0034, 16'h0012, 16'h00F0 and BE=2'b11 -> R1..R7 hold those values and WR_CNT=7. Then RA=3, RB=6 -> QA=16'h0078, QB=16'h0012.
- Byte lanes: R2=16'h1234, then write WA=2, WD=16'hABCD, BE=2'b01 -> R2=16'h12CD. Then BE=2'b10, WD=16'h5500 -> R2=16'h55CD. Then BE=2'b00 -> R2 unchanged and WR_CNT unchanged.
- R0 hardwire (R0_ZERO=1): WE=1, WA=0, WD=16'hDEAD, BE=2'b11 -> R0=0, QA(RA=0)=0, WR_CNT unchanged. With R0_ZERO=0 the same stimulus -> R0=16'hDEAD.
- Bypass: BYPASS=1, R4=16'h1111, WE=1, WA=4, RA=4, WD=16'h2222, BE=2'b01 -> QA=16'h1122 before the edge. With BYPASS=0 -> QA=16'h1111 before the edge and 16'h1122 after it.
- Reset vs write plus counter wrap: RST asserted in the write cycle (WA=5, WD=16'h7777) -> R5=0 after the edge. Separately, 256 committed writes -> WR_CNT returns to 0.

Source files
------------

// File: rtl/register_bank_8x16.sv
// register_bank_8x16
// Eight-entry general-purpose register bank for the single-cycle RISC datapath.
// One synchronous write port with byte-lane enables, two combinational read
// ports (A/B) with optional write-through, and all eight registers exposed in
// parallel for the downstream 8-to-1 operand multiplexers.
module register_bank_8x16 #(
  parameter int unsigned      WIDTH    = 16,
  parameter bit               R0_ZERO  = 1'b1,
  parameter bit               BYPASS   = 1'b0,
  parameter logic [WIDTH-1:0] R7_RESET = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [1:0]       BE,
  input  logic [2:0]       RA,
  input  logic [2:0]       RB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [7:0]       WR_CNT
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       wr_cnt_q;
  logic [7:0]       wr_cnt_d;

  logic             commit;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] merged_wd;

  // Decide whether this cycle's write really lands, and build the lane-merged word.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    commit    = WE && (BE != 2'b00) && !(R0_ZERO && (WA == 3'd0));
    lane_mask = {{HALF{BE[1]}}, {HALF{BE[0]}}};
    merged_wd = (WD & lane_mask) | (regs_q[WA] & ~lane_mask);
  end

  // Next-state: only the addressed register changes, and only on a committed write.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[WA] = merged_wd;
      wr_cnt_d   = wr_cnt_q + 8'd1;
    end
  end

  // State registers; reset is asynchronous and overrides any write in flight.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the register array is reset explicitly because it is built from flops and
    // must come up with known values (R7 is the stack pointer).
    if (RST) begin
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[7] <= R7_RESET;
      wr_cnt_q  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read ports: stored value, or the merged write word when write-through is enabled.
  always_comb begin
    QA = regs_q[RA];
    QB = regs_q[RB];
    if (BYPASS && commit) begin
      if (RA == WA) QA = merged_wd;
      if (RB == WA) QB = merged_wd;
    end
  end

  // Parallel register outputs for the operand muxes; never bypassed.
  assign R0     = regs_q[0];
  assign R1     = regs_q[1];
  assign R2     = regs_q[2];
  assign R3     = regs_q[3];
  assign R4     = regs_q[4];
  assign R5     = regs_q[5];
  assign R6     = regs_q[6];
  assign R7     = regs_q[7];
  assign WR_CNT = wr_cnt_q;

endmodule
